sram_byte_bridge: RTL

Parametrised bridge between the SoC core's byte-wide SRAM port (separate write and read channels, one-cycle read latency) and a wide 1RW1R SRAM macro with per-byte write mask. It generalises the fixed 32-bit lane-select/mirror adapter to any power-of-two macro width and depth. It adds an optional write-combining buffer that merges byte writes into one masked macro write, with read bypass so the core always sees coherent data. It sits between `subservient` and the SRAM macro inside the user project wrapper.

---
 rtl/sram_bridge_pkg.sv | 42 ++++
 rtl/sram_byte_bridge_if.sv | 42 ++++
 rtl/sram_wcb.sv | 130 +++++++++++++
 rtl/sram_byte_bridge.sv | 118 +++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and helpers for the byte-to-wide SRAM bridge.
// Holds address split helpers (word/lane), the one-hot lane mask helper and
// the write-combining buffer entry type. Widths are sized for the largest
// supported macro (128-bit data, 16 lanes, 16-bit word address); users
// narrow them with casts.
package sram_bridge_pkg;

    localparam int MAX_NB  = 16;
    localparam int MAX_DW  = 128;
    localparam int MAX_WAW = 16;

    typedef struct packed {
        logic               valid;
        logic [MAX_WAW-1:0] word;
        logic [MAX_DW-1:0]  data;
        logic [MAX_NB-1:0]  mask;
    } wcb_entry_t;

    // Macro word index of a core byte address.
    function automatic logic [MAX_WAW-1:0] word_of(input logic [31:0] addr,
                                                    input int unsigned lw,
                                                    input int unsigned waw);
        return MAX_WAW'((addr >> lw) & ((32'd1 << waw) - 32'd1));
    endfunction

    // Byte lane of a core byte address.
    function automatic logic [3:0] lane_of(input logic [31:0] addr,
                                            input int unsigned lw);
        return 4'(addr & ((32'd1 << lw) - 32'd1));
    endfunction

    // One-hot byte mask for a lane; all zeros if the lane is out of range.
    function automatic logic [MAX_NB-1:0] onehot_mask(input int unsigned lane,
                                                       input int unsigned nb);
        if (lane < nb) begin
            return MAX_NB'(32'd1 << lane);
        end else begin
            return {MAX_NB{1'b0}};
        end
    endfunction

endpackage

// File: rtl/sram_byte_bridge_if.sv
// Bundle of the core-side byte port, the flush/idle sideband and the
// macro-side 1RW1R port of sram_byte_bridge.
//   slave  : bridge view (core requests in, macro commands out)
//   master : environment view (drives core requests and macro read data)
interface sram_byte_bridge_if #(
    parameter int AW  = 13,
    parameter int DW  = 32,
    parameter int WAW = 8
);
    localparam int NB = DW / 8;

    logic [AW-1:0]  i_sram_waddr;
    logic [7:0]     i_sram_wdata;
    logic           i_sram_wen;
    logic [AW-1:0]  i_sram_raddr;
    logic           i_sram_ren;
    logic [7:0]     o_sram_rdata;
    logic           i_flush;
    logic           o_idle;
    logic           o_mem_we;
    logic [NB-1:0]  o_mem_wmask;
    logic [WAW-1:0] o_mem_waddr;
    logic [DW-1:0]  o_mem_wdata;
    logic           o_mem_re;
    logic [WAW-1:0] o_mem_raddr;
    logic [DW-1:0]  i_mem_rdata;

    modport slave (
        input  i_sram_waddr, i_sram_wdata, i_sram_wen, i_sram_raddr, i_sram_ren,
        input  i_flush, i_mem_rdata,
        output o_sram_rdata, o_idle, o_mem_we, o_mem_wmask, o_mem_waddr,
        output o_mem_wdata, o_mem_re, o_mem_raddr
    );

    modport master (
        output i_sram_waddr, i_sram_wdata, i_sram_wen, i_sram_raddr, i_sram_ren,
        output i_flush, i_mem_rdata,
        input  o_sram_rdata, o_idle, o_mem_we, o_mem_wmask, o_mem_waddr,
        input  o_mem_wdata, o_mem_re, o_mem_raddr
    );

endinterface

// File: rtl/sram_wcb.sv
// Single-entry write-combining buffer for sram_byte_bridge (built only when
// SRAM_BRIDGE_WCB_EN is defined).
// Merges byte writes to one macro word and emits a single masked macro write
// when the mask fills, the buffer idles FLUSH_IDLE cycles, a flush is forced,
// or a write to another word arrives. Also answers a read-bypass lookup
// against the post-update view (flushed word or next buffer contents).
// Ports: clk/rst_n; wen/wword/wlane/wdata incoming byte write; flush_req;
// rword/rlane bypass lookup -> byp_hit/byp_byte; mem_* macro write port; idle.
module sram_wcb
    import sram_bridge_pkg::*;
#(
    parameter int DW         = 32,
    parameter int WAW        = 8,
    parameter int LW         = 2,
    parameter int FLUSH_IDLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [WAW-1:0]    wword,
    input  logic [LW-1:0]     wlane,
    input  logic [7:0]        wdata,
    input  logic              flush_req,
    input  logic [WAW-1:0]    rword,
    input  logic [LW-1:0]     rlane,
    output logic              byp_hit,
    output logic [7:0]        byp_byte,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_wmask,
    output logic [WAW-1:0]    mem_waddr,
    output logic [DW-1:0]     mem_wdata,
    output logic              idle
);
    localparam int NB = DW / 8;
    localparam int CW = $clog2(FLUSH_IDLE + 1);
    localparam logic [MAX_NB-1:0] FULL_MASK = MAX_NB'((33'd1 << NB) - 33'd1);
    localparam wcb_entry_t EMPTY_ENTRY = {$bits(wcb_entry_t){1'b0}};

    wcb_entry_t        ent_r, nx_s, fl_s, merged_s, load_s;
    logic [CW-1:0]     cnt_r, cnt_nx_s;
    logic              idle_r;
    logic              flush_s, same_word_s, byp_fl_s, byp_nx_s;
    logic [MAX_NB-1:0] lane_mask_s;
    logic [6:0]        wbit_s, rbit_s;

    // Flush decision, merge/load of the incoming byte and idle counter update.
    always_comb begin
        lane_mask_s = onehot_mask(32'(wlane), 32'(NB));
        wbit_s      = 7'({wlane, 3'b000});
        same_word_s = (ent_r.word == MAX_WAW'(wword));

        merged_s                   = ent_r;
        merged_s.data[wbit_s +: 8] = wdata;
        merged_s.mask              = ent_r.mask | lane_mask_s;

        load_s                   = EMPTY_ENTRY;
        load_s.valid             = 1'b1;
        load_s.word              = MAX_WAW'(wword);
        load_s.data[wbit_s +: 8] = wdata;
        load_s.mask              = lane_mask_s;

        flush_s = ent_r.valid && ((ent_r.mask == FULL_MASK) ||
                                  (cnt_r == CW'(FLUSH_IDLE)) ||
                                  flush_req ||
                                  (wen && !same_word_s));

        fl_s     = EMPTY_ENTRY;
        nx_s     = ent_r;
        cnt_nx_s = cnt_r;
        if (flush_s) begin
            cnt_nx_s = CW'(0);
            if (wen && same_word_s) begin
                // Late byte rides along with the outgoing word.
                fl_s = merged_s;
                nx_s = EMPTY_ENTRY;
            end else if (wen) begin
                fl_s = ent_r;
                nx_s = load_s;
            end else begin
                fl_s = ent_r;
                nx_s = EMPTY_ENTRY;
            end
        end else if (wen) begin
            // Without a flush, a valid entry can only be hit by its own word.
            cnt_nx_s = CW'(0);
            if (ent_r.valid) begin
                nx_s = merged_s;
            end else begin
                nx_s = load_s;
            end
        end else if (ent_r.valid && (cnt_r != CW'(FLUSH_IDLE))) begin
            cnt_nx_s = cnt_r + CW'(1);
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Read bypass against the flushed word and the updated buffer entry.
    always_comb begin
        rbit_s   = 7'({rlane, 3'b000});
        byp_fl_s = flush_s && (fl_s.word == MAX_WAW'(rword)) && fl_s.mask[4'(rlane)];
        byp_nx_s = nx_s.valid && (nx_s.word == MAX_WAW'(rword)) && nx_s.mask[4'(rlane)];
        byp_hit  = byp_fl_s || byp_nx_s;
        if (byp_nx_s) begin
            byp_byte = nx_s.data[rbit_s +: 8];
        end else begin
            byp_byte = fl_s.data[rbit_s +: 8];
        end
    end

    assign mem_we    = flush_s;
    assign mem_waddr = WAW'(fl_s.word);
    assign mem_wdata = fl_s.data[DW-1:0];
    assign mem_wmask = fl_s.mask[NB-1:0];
    assign idle      = idle_r;

    // Buffer entry, idle counter and registered idle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_r  <= EMPTY_ENTRY;
            cnt_r  <= CW'(0);
            idle_r <= 1'b1;
        end else begin
            ent_r  <= nx_s;
            cnt_r  <= cnt_nx_s;
            idle_r <= !nx_s.valid;
        end
    end

endmodule

// File: rtl/sram_byte_bridge.sv
// Bridge from the core's byte-wide SRAM port (separate write/read channels,
// one-cycle read latency) to a DW-bit 1RW1R SRAM macro with byte write mask.
// Define SRAM_BRIDGE_WCB_EN to insert the write-combining buffer (sram_wcb);
// otherwise each byte write goes straight to the macro in the same cycle.
// Ports: i_clk, i_rst_n (async active-low); bus (sram_byte_bridge_if.slave)
// carrying the core byte port, i_flush/o_idle and the macro ports.
module sram_byte_bridge
    import sram_bridge_pkg::*;
#(
    parameter int DW         = 32,
    parameter int DEPTH      = 256,
    parameter int AW         = 13,
    parameter int FLUSH_IDLE = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sram_byte_bridge_if.slave  bus
);
    localparam int NB  = DW / 8;
    localparam int LW  = $clog2(NB);
    localparam int WAW = $clog2(DEPTH);

    logic [WAW-1:0] wword_s, rword_s;
    logic [LW-1:0]  wlane_s, rlane_s;
    logic           byp_hit_s;
    logic [7:0]     byp_byte_s, rdata_s;
    logic           rd_pend_r, byp_flag_r;
    logic [LW-1:0]  rd_lane_r;
    logic [7:0]     byp_byte_r, hold_r;

    assign wword_s = WAW'(word_of(32'(bus.i_sram_waddr), 32'(LW), 32'(WAW)));
    assign wlane_s = LW'(lane_of(32'(bus.i_sram_waddr), 32'(LW)));
    assign rword_s = WAW'(word_of(32'(bus.i_sram_raddr), 32'(LW), 32'(WAW)));
    assign rlane_s = LW'(lane_of(32'(bus.i_sram_raddr), 32'(LW)));

    // Macro read is issued combinationally; held low while in reset.
    assign bus.o_mem_re    = bus.i_sram_ren & i_rst_n;
    assign bus.o_mem_raddr = i_rst_n ? rword_s : {WAW{1'b0}};

`ifdef SRAM_BRIDGE_WCB_EN
    sram_wcb #(
        .DW         (DW),
        .WAW        (WAW),
        .LW         (LW),
        .FLUSH_IDLE (FLUSH_IDLE)
    ) u_wcb (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .wen       (bus.i_sram_wen),
        .wword     (wword_s),
        .wlane     (wlane_s),
        .wdata     (bus.i_sram_wdata),
        .flush_req (bus.i_flush),
        .rword     (rword_s),
        .rlane     (rlane_s),
        .byp_hit   (byp_hit_s),
        .byp_byte  (byp_byte_s),
        .mem_we    (bus.o_mem_we),
        .mem_wmask (bus.o_mem_wmask),
        .mem_waddr (bus.o_mem_waddr),
        .mem_wdata (bus.o_mem_wdata),
        .idle      (bus.o_idle)
    );
`else
    logic unused_flush_s;

    // Direct path: byte replicated across lanes, mask selects the lane.
    assign bus.o_mem_we    = bus.i_sram_wen & i_rst_n;
    assign bus.o_mem_wmask = i_rst_n ? NB'(onehot_mask(32'(wlane_s), 32'(NB))) : {NB{1'b0}};
    assign bus.o_mem_waddr = i_rst_n ? wword_s : {WAW{1'b0}};
    assign bus.o_mem_wdata = i_rst_n ? {NB{bus.i_sram_wdata}} : {DW{1'b0}};
    assign bus.o_idle      = 1'b1;
    assign unused_flush_s  = bus.i_flush;

    // The macro returns pre-write data, so a same-cycle write to the read byte wins.
    assign byp_hit_s  = bus.i_sram_wen && (wword_s == rword_s) && (wlane_s == rlane_s);
    assign byp_byte_s = bus.i_sram_wdata;
`endif

    // Returned byte: bypass value if captured, else the addressed macro lane.
    always_comb begin
        if (byp_flag_r) begin
            rdata_s = byp_byte_r;
        end else begin
            rdata_s = bus.i_mem_rdata[{rd_lane_r, 3'b000} +: 8];
        end
    end

    assign bus.o_sram_rdata = rd_pend_r ? rdata_s : hold_r;

    // Read request capture and last-returned-byte hold register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pend_r  <= 1'b0;
            rd_lane_r  <= {LW{1'b0}};
            byp_flag_r <= 1'b0;
            byp_byte_r <= 8'h00;
            hold_r     <= 8'h00;
        end else begin
            rd_pend_r <= bus.i_sram_ren;
            if (bus.i_sram_ren) begin
                rd_lane_r  <= rlane_s;
                byp_flag_r <= byp_hit_s;
                byp_byte_r <= byp_byte_s;
            end else begin
                rd_lane_r  <= rd_lane_r;
                byp_flag_r <= byp_flag_r;
                byp_byte_r <= byp_byte_r;
            end
            if (rd_pend_r) begin
                hold_r <= rdata_s;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

endmodule
